// File: rtl/cnn_load_scheduler.sv
// Layer-level load sequencer: RAM init, per-pass conv start, weight-RAM update handshake.
// Optional: define SCHED_TIMEOUT_EN to bound every handshake wait by TIMEOUT cycles.
module cnn_load_scheduler #(
  parameter int PARA_KERNEL = 8,
  parameter int WADDR_W     = 6,
  parameter int PASS_W      = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic [PASS_W-1:0]              num_pass,
  output logic                           init,
  input  logic                           init_fm_ram_ready,
  input  logic                           init_weight_ram_ready,
  output logic                           update_weight_ram,
  output logic [WADDR_W*PARA_KERNEL-1:0] update_weight_ram_addr,
  input  logic                           weight_data_done,
  output logic                           conv_start,
  input  logic                           conv_done,
  output logic                           busy,
  output logic [PASS_W-1:0]              pass_idx,
  output logic                           layer_done,
  output logic                           err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_RAM, S_CONV, S_UPD_REQ, S_UPD_WAIT, S_DONE
  } state_t;

  state_t                           state, state_nx;
  logic [PASS_W-1:0]                npass, pass_q;
  logic                             fm_cap, wt_cap;
  logic                             conv_first;
  logic [WADDR_W*PARA_KERNEL-1:0]   addr_q, addr_nx;
  logic                             rams_ready, last_pass, go_accept;
  logic                             timeout_hit;

  assign go_accept  = (state == S_IDLE) && go;
  assign rams_ready = (fm_cap | init_fm_ram_ready) && (wt_cap | init_weight_ram_ready);
  assign last_pass  = ((pass_q + PASS_W'(1)) == npass);

  // Addresses for the kernel group of the pass about to start.
  always_comb begin
    addr_nx = '0;
    for (int k = 0; k < PARA_KERNEL; k++)
      addr_nx[k*WADDR_W +: WADDR_W] = WADDR_W'((int'(pass_q) + 1) * PARA_KERNEL + k);
  end

  // NOTE: assign every always_comb output a default before the case, otherwise a latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (go) state_nx = S_INIT;
      S_INIT:     state_nx = S_WAIT_RAM;
      S_WAIT_RAM: if (rams_ready) state_nx = S_CONV;
      S_CONV:     if (conv_done) state_nx = last_pass ? S_DONE : S_UPD_REQ;
      S_UPD_REQ:  if (weight_data_done) state_nx = S_UPD_WAIT;
      S_UPD_WAIT: if (!weight_data_done) state_nx = S_CONV;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    // Progress in the same cycle wins over an expiring wait.
    if (timeout_hit && (state_nx == state)) state_nx = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      npass      <= '0;
      pass_q     <= '0;
      fm_cap     <= 1'b0;
      wt_cap     <= 1'b0;
      conv_first <= 1'b0;
      addr_q     <= '0;
    end else begin
      state      <= state_nx;
      conv_first <= (state_nx == S_CONV) && (state != S_CONV);
      if (go_accept) begin
        npass  <= (num_pass == '0) ? PASS_W'(1) : num_pass;
        pass_q <= '0;
        fm_cap <= 1'b0;
        wt_cap <= 1'b0;
      end
      if (state == S_WAIT_RAM) begin
        fm_cap <= fm_cap | init_fm_ram_ready;
        wt_cap <= wt_cap | init_weight_ram_ready;
      end
      if ((state == S_CONV) && conv_done && !last_pass) begin
        pass_q <= pass_q + PASS_W'(1);
        addr_q <= addr_nx;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             err_q;

  assign waiting     = state inside {S_WAIT_RAM, S_CONV, S_UPD_REQ, S_UPD_WAIT};
  assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_nx != state) wait_cnt <= '0;
      else if (waiting)      wait_cnt <= wait_cnt + CNT_W'(1);
      if (go_accept)                               err_q <= 1'b0;
      else if (timeout_hit && state_nx == S_IDLE)  err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign init                   = (state == S_INIT);
  assign conv_start             = (state == S_CONV) && conv_first;
  assign layer_done             = (state == S_DONE);
  assign update_weight_ram      = (state == S_UPD_REQ);
  assign busy                   = (state != S_IDLE);
  assign pass_idx               = pass_q;
  assign update_weight_ram_addr = addr_q;

endmodule

// File: tb/tb_cnn_load_scheduler.sv
// Directed bench for cnn_load_scheduler; a second instance with 4-bit address fields checks wrap.
module tb_cnn_load_scheduler;
  localparam int PK = 8;
  localparam int WW = 6;
  localparam int PW = 8;
  localparam int TB_TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, fm_rdy = 1'b0, wt_rdy = 1'b0, wdd = 1'b0, cdone = 1'b0;
  logic [PW-1:0] num_pass = '0;

  logic          init, upd, conv_start, busy, layer_done, err_timeout;
  logic [WW*PK-1:0] upd_addr;
  logic [PW-1:0] pass_idx;

  logic          w_init, w_upd, w_conv_start, w_busy, w_layer_done, w_err_timeout;
  logic [4*PK-1:0] w_addr;
  logic [PW-1:0] w_pass_idx;

  int errors = 0;
  int checks = 0;
  int n_cs = 0;
  int n_ld = 0;

  cnn_load_scheduler #(.PARA_KERNEL(PK), .WADDR_W(WW), .PASS_W(PW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .go(go), .num_pass(num_pass), .init(init),
    .init_fm_ram_ready(fm_rdy), .init_weight_ram_ready(wt_rdy),
    .update_weight_ram(upd), .update_weight_ram_addr(upd_addr),
    .weight_data_done(wdd), .conv_start(conv_start), .conv_done(cdone),
    .busy(busy), .pass_idx(pass_idx), .layer_done(layer_done), .err_timeout(err_timeout)
  );

  cnn_load_scheduler #(.PARA_KERNEL(PK), .WADDR_W(4), .PASS_W(PW), .TIMEOUT(TB_TIMEOUT)) u_wrap (
    .clk(clk), .rst(rst), .go(go), .num_pass(num_pass), .init(w_init),
    .init_fm_ram_ready(fm_rdy), .init_weight_ram_ready(wt_rdy),
    .update_weight_ram(w_upd), .update_weight_ram_addr(w_addr),
    .weight_data_done(wdd), .conv_start(w_conv_start), .conv_done(cdone),
    .busy(w_busy), .pass_idx(w_pass_idx), .layer_done(w_layer_done), .err_timeout(w_err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_start) n_cs++;
    if (layer_done) n_ld++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle's inputs just after the edge, then leaves time for outputs to settle.
  task automatic cycle(input logic r, input logic g, input logic f, input logic w,
                       input logic d, input logic c);
    @(posedge clk);
    #1;
    rst = r; go = g; fm_rdy = f; wt_rdy = w; wdd = d; cdone = c;
    #2;
  endtask

  task automatic chk_ctl(input string t, input int c, input logic e_init, input logic e_cs,
                         input logic e_ld, input logic e_busy, input logic e_upd);
    check($sformatf("%s_init@%0d", t, c), init, e_init);
    check($sformatf("%s_conv_start@%0d", t, c), conv_start, e_cs);
    check($sformatf("%s_layer_done@%0d", t, c), layer_done, e_ld);
    check($sformatf("%s_busy@%0d", t, c), busy, e_busy);
    check($sformatf("%s_upd@%0d", t, c), upd, e_upd);
  endtask

  function automatic logic [WW*PK-1:0] fields6(input int base);
    logic [WW*PK-1:0] v;
    v = '0;
    for (int k = 0; k < PK; k++) v[k*WW +: WW] = WW'(base + k);
    return v;
  endfunction

  initial begin
    // Reset state
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk_ctl("rst", 0, 0, 0, 0, 0, 0);
    check("rst_pass_idx", pass_idx, 0);
    check("rst_addr", upd_addr, 0);
    check("rst_err", err_timeout, 0);

    // Single pass, num_pass=0 treated as 1
    num_pass = 0;
    for (int c = 0; c <= 22; c++) begin
      cycle(0, c == 0, c == 5, c == 5, 0, c == 20);
      chk_ctl("single", c, c == 1, c == 6, c == 21, (c >= 1 && c <= 21), 0);
    end

    // Staggered readies
    num_pass = 1;
    for (int c = 0; c <= 14; c++) begin
      cycle(0, c == 0, c == 4, c == 9, 0, c == 12);
      chk_ctl("stagger", c, c == 1, c == 10, c == 13, (c >= 1 && c <= 13), 0);
    end

    // Three passes with two weight updates
    num_pass = 3;
    n_cs = 0;
    n_ld = 0;
    for (int c = 0; c <= 21; c++) begin
      cycle(0, c == 0, c == 2, c == 2, (c == 8 || c == 9 || c == 15),
            (c == 5 || c == 13 || c == 19));
      chk_ctl("three", c, c == 1, (c == 3 || c == 11 || c == 17), c == 20,
              (c >= 1 && c <= 20), ((c >= 6 && c <= 8) || (c >= 14 && c <= 15)));
      check($sformatf("three_pass_idx@%0d", c), pass_idx, (c < 6) ? 0 : (c < 14) ? 1 : 2);
      if (c == 6 || c == 8) begin
        check($sformatf("three_addr@%0d", c), upd_addr, fields6(8));
        check($sformatf("wrap_addr@%0d", c), w_addr, 32'hFEDC_BA98);
      end
      if (c == 14 || c == 15 || c == 21) begin
        check($sformatf("three_addr@%0d", c), upd_addr, fields6(16));
        check($sformatf("wrap_addr@%0d", c), w_addr, 32'h7654_3210);
      end
    end
    check("three_wrap_field0", w_addr[3:0], 0);
    check("three_wrap_field1", w_addr[7:4], 1);
    check("three_conv_start_count", n_cs, 3);
    check("three_layer_done_count", n_ld, 1);

    // go during CONV ignored; conv_done in IDLE ignored
    num_pass = 1;
    for (int c = 0; c <= 11; c++) begin
      if (c == 5) num_pass = 5;
      cycle(0, (c == 0 || c == 5), c == 2, c == 2, 0, (c == 7 || c == 10));
      chk_ctl("robust", c, c == 1, c == 3, c == 8, (c >= 1 && c <= 8), 0);
    end
    check("robust_pass_idx", pass_idx, 0);

    // Reset in UPD_REQ aborts, new go restarts from INIT
    num_pass = 2;
    for (int c = 0; c <= 13; c++) begin
      cycle(c == 6, (c == 0 || c == 8), (c == 2 || c == 10), (c == 2 || c == 10), 0,
            (c == 4 || c == 12));
      chk_ctl("abort", c, (c == 1 || c == 9), (c == 3 || c == 11), 0,
              ((c >= 1 && c <= 6) || (c >= 9 && c <= 13)), (c == 5 || c == 6 || c == 13));
      if (c == 7) begin
        check("abort_pass_idx", pass_idx, 0);
        check("abort_addr", upd_addr, 0);
        check("abort_err", err_timeout, 0);
      end
    end
    check("abort_restart_addr", upd_addr, fields6(8));
    check("abort_restart_pass_idx", pass_idx, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk_ctl("post_rst", 0, 0, 0, 0, 0, 0);

`ifdef SCHED_TIMEOUT_EN
    // Readies never arrive: timeout after TB_TIMEOUT cycles in WAIT_RAM
    num_pass = 1;
    for (int c = 0; c <= 47; c++) begin
      cycle(0, (c == 0 || c == 45), 0, 0, 0, 0);
      check($sformatf("tmo_err@%0d", c), err_timeout, (c >= 42 && c <= 45));
      chk_ctl("tmo", c, (c == 1 || c == 46), 0, 0, ((c >= 1 && c <= 41) || c >= 46), 0);
    end
`else
    // Without the timeout feature waits are unbounded and err_timeout stays 0
    num_pass = 1;
    for (int c = 0; c <= 59; c++) begin
      cycle(0, c == 0, 0, 0, 0, 0);
      if (c % 10 == 0) begin
        check($sformatf("notmo_err@%0d", c), err_timeout, 0);
        check($sformatf("notmo_busy@%0d", c), busy, c >= 1);
      end
    end
`endif
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk_ctl("final", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
